// File: rtl/instr_encoder_loader_if.sv
// Instruction-stream and instruction-memory bus between the program source and the loader.
// The master drives the symbolic fields; the slave (the loader) returns ready and the memory writes.
interface instr_encoder_loader_if #(
  parameter int ADDR_W = 8
);
  logic              in_valid;
  logic              in_ready;
  logic              in_last;
  logic [3:0]        in_mnem;
  logic [4:0]        in_rs;
  logic [4:0]        in_rt;
  logic [4:0]        in_rd;
  logic [15:0]       in_imm;
  logic [25:0]       in_target;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;

  modport master (
    output in_valid, in_last, in_mnem, in_rs, in_rt, in_rd, in_imm, in_target,
    input  in_ready, imem_we, imem_addr, imem_wdata
  );

  modport slave (
    input  in_valid, in_last, in_mnem, in_rs, in_rt, in_rd, in_imm, in_target,
    output in_ready, imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/instr_encoder_loader.sv
// Boot loader: packs symbolic MIPS instructions into 32-bit words and writes them
// sequentially into instruction memory, one session per start pulse.
module instr_encoder_loader #(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       start,
  instr_encoder_loader_if.slave      bus,
  output logic [ADDR_W:0]            word_count,
  output logic                       err,
  output logic                       full,
  output logic                       done
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

  localparam logic [3:0] M_ADD  = 4'd0;
  localparam logic [3:0] M_SUB  = 4'd1;
  localparam logic [3:0] M_AND  = 4'd2;
  localparam logic [3:0] M_OR   = 4'd3;
  localparam logic [3:0] M_SLT  = 4'd4;
  localparam logic [3:0] M_LW   = 4'd5;
  localparam logic [3:0] M_SW   = 4'd6;
  localparam logic [3:0] M_BEQ  = 4'd7;
  localparam logic [3:0] M_BNE  = 4'd8;
  localparam logic [3:0] M_ADDI = 4'd9;
  localparam logic [3:0] M_ANDI = 4'd10;
  localparam logic [3:0] M_SLTI = 4'd11;
  localparam logic [3:0] M_ORI  = 4'd12;
  localparam logic [3:0] M_J    = 4'd13;

  logic [1:0]        state_q, state_d;
  logic              imem_we_q, imem_we_d;
  logic [ADDR_W-1:0] imem_addr_q, imem_addr_d;
  logic [31:0]       imem_wdata_q, imem_wdata_d;
  logic [ADDR_W:0]   word_count_q, word_count_d;
  logic              err_q, err_d;
  logic              full_q, full_d;

  logic        accept;
  logic        enc_legal;
  logic [31:0] enc_word;
  logic [5:0]  funct;
  logic [5:0]  opcode;

  // Encoder: R-type shares opcode 0 and differs only in funct; I-type differs in opcode.
  always_comb begin
    enc_legal = 1'b1;
    funct     = 6'h00;
    opcode    = 6'h00;
    enc_word  = 32'h0;
    case (bus.in_mnem)
      M_ADD:  funct  = 6'h20;
      M_SUB:  funct  = 6'h22;
      M_AND:  funct  = 6'h24;
      M_OR:   funct  = 6'h25;
      M_SLT:  funct  = 6'h2A;
      M_LW:   opcode = 6'h23;
      M_SW:   opcode = 6'h2B;
      M_BEQ:  opcode = 6'h04;
      M_BNE:  opcode = 6'h05;
      M_ADDI: opcode = 6'h08;
      M_ANDI: opcode = 6'h0C;
      M_SLTI: opcode = 6'h0A;
      M_ORI:  opcode = 6'h0D;
      M_J:    opcode = 6'h02;
      default: enc_legal = 1'b0;
    endcase
    if (bus.in_mnem <= M_SLT)
      enc_word = {6'h00, bus.in_rs, bus.in_rt, bus.in_rd, 5'd0, funct};
    else if (bus.in_mnem == M_J)
      enc_word = {opcode, bus.in_target};
    else
      enc_word = {opcode, bus.in_rs, bus.in_rt, bus.in_imm};
  end

  assign accept = bus.in_valid && (state_q == S_LOAD);

  always_comb begin
    state_d      = state_q;
    imem_we_d    = 1'b0;
    imem_addr_d  = imem_addr_q;
    imem_wdata_d = imem_wdata_q;
    word_count_d = word_count_q;
    err_d        = err_q;
    full_d       = full_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d      = S_LOAD;
          imem_addr_d  = '0;
          word_count_d = '0;
          err_d        = 1'b0;
          full_d       = 1'b0;
        end
      end
      S_LOAD: begin
        if (accept) begin
          // Illegal beats are consumed so the source never deadlocks, but write nothing.
          if (enc_legal) begin
            imem_we_d    = 1'b1;
            imem_wdata_d = enc_word;
            imem_addr_d  = word_count_q[ADDR_W-1:0];
            word_count_d = word_count_q + 1'b1;
            if (word_count_d == FULL_CNT) full_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
          if (bus.in_last || full_d) state_d = S_FLUSH;
        end
      end
      S_FLUSH: state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= '0;
      word_count_q <= '0;
      err_q        <= 1'b0;
      full_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      imem_we_q    <= imem_we_d;
      imem_addr_q  <= imem_addr_d;
      imem_wdata_q <= imem_wdata_d;
      word_count_q <= word_count_d;
      err_q        <= err_d;
      full_q       <= full_d;
    end
  end

  assign bus.in_ready   = (state_q == S_LOAD);
  assign bus.imem_we    = imem_we_q;
  assign bus.imem_addr  = imem_addr_q;
  assign bus.imem_wdata = imem_wdata_q;
  assign word_count     = word_count_q;
  assign err            = err_q;
  assign full           = full_q;
  assign done           = (state_q == S_DONE);

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Directed table-driven bench for the instruction encoder/loader (DEPTH=4 so the full
// threshold is reachable), plus hand sequences for session end, full and reset abort.
module tb_instr_encoder_loader;
  localparam int ADDR_W = 8;
  localparam int DEPTH  = 4;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic start = 1'b0;
  logic [ADDR_W:0] word_count;
  logic err, full, done;

  instr_encoder_loader_if #(.ADDR_W(ADDR_W)) bus();

  instr_encoder_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .bus(bus),
    .word_count(word_count), .err(err), .full(full), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  mnem;
    logic [4:0]  rs, rt, rd;
    logic [15:0] imm;
    logic [25:0] tgt;
    logic        last;
    logic        we;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [8:0]  wc;
    logic        err;
  } vec_t;

  vec_t vt[16];
  int errors = 0;
  int checks = 0;

  function automatic vec_t mk(logic [3:0] m, logic [4:0] rs, logic [4:0] rt, logic [4:0] rd,
                              logic [15:0] imm, logic [25:0] tgt, logic last, logic we,
                              logic [7:0] addr, logic [31:0] wd, logic [8:0] wc, logic e);
    vec_t v;
    v.mnem = m; v.rs = rs; v.rt = rt; v.rd = rd; v.imm = imm; v.tgt = tgt; v.last = last;
    v.we = we; v.addr = addr; v.wdata = wd; v.wc = wc; v.err = e;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input vec_t v);
    bus.in_mnem = v.mnem; bus.in_rs = v.rs; bus.in_rt = v.rt; bus.in_rd = v.rd;
    bus.in_imm = v.imm; bus.in_target = v.tgt; bus.in_last = v.last;
  endtask

  // Valid stays high across consecutive vectors, so each edge in LOAD accepts one beat.
  task automatic run_vecs(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      drive(vt[i]);
      bus.in_valid = 1'b1;
      step();
      chk($sformatf("v%0d_we", i), 64'(bus.imem_we), 64'(vt[i].we));
      if (vt[i].we) chk($sformatf("v%0d_wdata", i), 64'(bus.imem_wdata), 64'(vt[i].wdata));
      chk($sformatf("v%0d_addr", i), 64'(bus.imem_addr), 64'(vt[i].addr));
      chk($sformatf("v%0d_wc", i), 64'(word_count), 64'(vt[i].wc));
      chk($sformatf("v%0d_err", i), 64'(err), 64'(vt[i].err));
    end
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
    chk("start_ready", 64'(bus.in_ready), 64'd1);
    chk("start_wc", 64'(word_count), 64'd0);
  endtask

  // Called right after the in_last accept: FLUSH now, DONE next cycle, then IDLE.
  task automatic finish_session(input string tag);
    bus.in_valid = 1'b0;
    chk({tag, "_flush_done"}, 64'(done), 64'd0);
    chk({tag, "_flush_ready"}, 64'(bus.in_ready), 64'd0);
    step();
    chk({tag, "_done"}, 64'(done), 64'd1);
    chk({tag, "_done_we"}, 64'(bus.imem_we), 64'd0);
    step();
    chk({tag, "_idle_done"}, 64'(done), 64'd0);
    chk({tag, "_idle_ready"}, 64'(bus.in_ready), 64'd0);
  endtask

  initial begin
    // mnem rs rt rd imm tgt last | we addr wdata wc err
    vt[0]  = mk(4'd0,  5'd1,  5'd2,  5'd3, 16'h0000, 26'h0,  1'b0, 1'b1, 8'd0, 32'h00221820, 9'd1, 1'b0);
    vt[1]  = mk(4'd5,  5'd9,  5'd8,  5'd0, 16'h0004, 26'h0,  1'b0, 1'b1, 8'd1, 32'h8D280004, 9'd2, 1'b0);
    vt[2]  = mk(4'd7,  5'd1,  5'd2,  5'd0, 16'hFFFF, 26'h0,  1'b0, 1'b1, 8'd2, 32'h1022FFFF, 9'd3, 1'b0);
    vt[3]  = mk(4'd13, 5'd0,  5'd0,  5'd0, 16'h0000, 26'h10, 1'b1, 1'b1, 8'd3, 32'h08000010, 9'd4, 1'b0);
    vt[4]  = mk(4'd1,  5'd4,  5'd5,  5'd6, 16'h0000, 26'h0,  1'b0, 1'b1, 8'd0, 32'h00853022, 9'd1, 1'b0);
    vt[5]  = mk(4'd14, 5'd7,  5'd7,  5'd7, 16'h1234, 26'h0,  1'b0, 1'b0, 8'd0, 32'h0,        9'd1, 1'b1);
    vt[6]  = mk(4'd12, 5'd3,  5'd7,  5'd0, 16'h00FF, 26'h0,  1'b0, 1'b1, 8'd1, 32'h346700FF, 9'd2, 1'b1);
    vt[7]  = mk(4'd4,  5'd1,  5'd2,  5'd3, 16'h0000, 26'h0,  1'b1, 1'b1, 8'd2, 32'h0022182A, 9'd3, 1'b1);
    vt[8]  = mk(4'd6,  5'd2,  5'd3,  5'd0, 16'h0010, 26'h0,  1'b0, 1'b1, 8'd0, 32'hAC430010, 9'd1, 1'b0);
    vt[9]  = mk(4'd8,  5'd0,  5'd0,  5'd0, 16'h8000, 26'h0,  1'b0, 1'b1, 8'd1, 32'h14008000, 9'd2, 1'b0);
    vt[10] = mk(4'd9,  5'd31, 5'd31, 5'd0, 16'hABCD, 26'h0,  1'b0, 1'b1, 8'd2, 32'h23FFABCD, 9'd3, 1'b0);
    vt[11] = mk(4'd15, 5'd1,  5'd1,  5'd1, 16'h0001, 26'h0,  1'b1, 1'b0, 8'd2, 32'h0,        9'd3, 1'b1);
    vt[12] = mk(4'd2,  5'd1,  5'd1,  5'd1, 16'h0000, 26'h0,  1'b0, 1'b1, 8'd0, 32'h00210824, 9'd1, 1'b0);
    vt[13] = mk(4'd3,  5'd2,  5'd2,  5'd2, 16'h0000, 26'h0,  1'b0, 1'b1, 8'd1, 32'h00421025, 9'd2, 1'b0);
    vt[14] = mk(4'd10, 5'd1,  5'd2,  5'd0, 16'h0F0F, 26'h0,  1'b0, 1'b1, 8'd2, 32'h30220F0F, 9'd3, 1'b0);
    vt[15] = mk(4'd11, 5'd5,  5'd6,  5'd0, 16'h7FFF, 26'h0,  1'b0, 1'b1, 8'd3, 32'h28A67FFF, 9'd4, 1'b0);

    bus.in_valid = 1'b0; bus.in_last = 1'b0; bus.in_mnem = '0; bus.in_rs = '0;
    bus.in_rt = '0; bus.in_rd = '0; bus.in_imm = '0; bus.in_target = '0;

    repeat (2) step();
    chk("rst_ready", 64'(bus.in_ready), 64'd0);
    chk("rst_we", 64'(bus.imem_we), 64'd0);
    chk("rst_addr", 64'(bus.imem_addr), 64'd0);
    chk("rst_wdata", 64'(bus.imem_wdata), 64'd0);
    chk("rst_wc", 64'(word_count), 64'd0);
    chk("rst_flags", 64'({err, full, done}), 64'd0);
    reset_n = 1'b1;

    // Valid while IDLE is ignored.
    drive(vt[0]);
    bus.in_valid = 1'b1;
    step(); step();
    chk("idle_valid_we", 64'(bus.imem_we), 64'd0);
    chk("idle_valid_wc", 64'(word_count), 64'd0);

    // Session A: ADD, LW, BEQ, J(last); the 4th word also reaches DEPTH.
    do_start();
    run_vecs(0, 3);
    finish_session("A");

    // Session B: illegal mnemonic between legal beats.
    do_start();
    run_vecs(4, 7);
    finish_session("B");
    chk("B_err_sticky", 64'(err), 64'd1);
    chk("B_not_full", 64'(full), 64'd0);

    // Session C: start held high during LOAD is ignored; illegal beat with last ends it.
    start = 1'b1;
    step();
    chk("C_err_cleared", 64'(err), 64'd0);
    run_vecs(8, 10);
    start = 1'b0;
    run_vecs(11, 11);
    finish_session("C");

    // Session D: four beats without last fill the memory; a 5th beat is never accepted.
    do_start();
    run_vecs(12, 15);
    drive(vt[0]);
    bus.in_valid = 1'b1;
    chk("D_full", 64'(full), 64'd1);
    chk("D_ready_low", 64'(bus.in_ready), 64'd0);
    step();
    chk("D_done", 64'(done), 64'd1);
    chk("D_no_write", 64'(bus.imem_we), 64'd0);
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("D_hold%0d_we", k), 64'(bus.imem_we), 64'd0);
      chk($sformatf("D_hold%0d_wc", k), 64'(word_count), 64'd4);
      chk($sformatf("D_hold%0d_ready", k), 64'(bus.in_ready), 64'd0);
    end
    chk("D_done_once", 64'(done), 64'd0);
    bus.in_valid = 1'b0;

    // Reset right after an accept drops the write and clears every output at once.
    do_start();
    drive(vt[12]);
    bus.in_valid = 1'b1;
    @(posedge clk);
    reset_n = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    chk("abort_we", 64'(bus.imem_we), 64'd0);
    chk("abort_ready", 64'(bus.in_ready), 64'd0);
    chk("abort_wdata", 64'(bus.imem_wdata), 64'd0);
    chk("abort_wc", 64'(word_count), 64'd0);
    chk("abort_flags", 64'({err, full, done}), 64'd0);
    step();
    reset_n = 1'b1;
    step();
    do_start();
    run_vecs(8, 8);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
